placement_cost_eval: RTL and testbench

Parametrised wirelength evaluator for the grid placement flow. It runs after placement has filled the position memories. It walks the edge list, fetches both endpoint positions, and accumulates a per-edge cost in one of three selectable metrics (Manhattan, 1-hop, Chebyshev). Memory read latency, data width and edge count are configurable, and a start/done handshake replaces the fixed end-of-flow evaluation.

---
 rtl/placement_cost_eval_if.sv | 43 ++++
 rtl/placement_cost_eval.sv | 153 +++++++++++++++
 tb/tb_placement_cost_eval.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/placement_cost_eval_if.sv
// placement_cost_eval_if: control and memory-read bus of the wirelength evaluator
// master: evaluator side (drives start-accept status, read strobes, addresses, cost/err)
// slave: host/memory side (drives start, n_edge, mode and memory read data)
// max_cost/max_idx exist only when PLACEMENT_COST_MAXTRACK_EN is defined
interface placement_cost_eval_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 40
);
  logic              start;
  logic [ADDR_W-1:0] n_edge;
  logic [1:0]        mode;
  logic              edge_re;
  logic [ADDR_W-1:0] edge_addr;
  logic [DATA_W-1:0] edge_a;
  logic [DATA_W-1:0] edge_b;
  logic              pos_re;
  logic [ADDR_W-1:0] pos_addr;
  logic [DATA_W-1:0] pos_x;
  logic [DATA_W-1:0] pos_y;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  cost;
  logic              err;
`ifdef PLACEMENT_COST_MAXTRACK_EN
  logic [DATA_W:0]   max_cost;
  logic [ADDR_W-1:0] max_idx;
`endif
  modport master(
`ifdef PLACEMENT_COST_MAXTRACK_EN
    output max_cost, max_idx,
`endif
    input  start, n_edge, mode, edge_a, edge_b, pos_x, pos_y,
    output edge_re, edge_addr, pos_re, pos_addr, busy, done, cost, err
  );
  modport slave(
`ifdef PLACEMENT_COST_MAXTRACK_EN
    input  max_cost, max_idx,
`endif
    output start, n_edge, mode, edge_a, edge_b, pos_x, pos_y,
    input  edge_re, edge_addr, pos_re, pos_addr, busy, done, cost, err
  );
endinterface

// File: rtl/placement_cost_eval.sv
// placement_cost_eval: walks the edge list and accumulates Manhattan/1-hop/Chebyshev wirelength
// Ports: clk, reset (async, active high), bus (placement_cost_eval_if.master):
//   start/n_edge/mode in, edge_re/edge_addr + edge_a/edge_b edge memory, pos_re/pos_addr + pos_x/pos_y
//   position memory, busy/done/cost/err status.
// Macro PLACEMENT_COST_MAXTRACK_EN adds max_cost/max_idx (largest per-edge cost, lowest index).
module placement_cost_eval #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int ACC_W   = 40,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic reset,
  placement_cost_eval_if.master bus
);
  typedef enum logic [3:0] {IDLE, E_ISSUE, E_WAIT, A_ISSUE, A_WAIT, B_ISSUE, B_WAIT, DIFF, ABS, ACC, DONE} state_t;
  localparam logic [15:0] WL = 16'(MEM_LAT - 1);
  state_t st;
  logic [ADDR_W-1:0] idx, nq, eb;
  logic [1:0] mq;
  logic [15:0] wc;
  logic [DATA_W-1:0] ax, ay, bx, by;
  logic [DATA_W:0] dx, dy;
  logic [DATA_W+1:0] hx, hy, s, c;
  logic [ACC_W:0] sum;
  logic bad;
  always_comb begin
    hx = mq == 2'd1 ? ({1'b0, dx} + 1'b1) >> 1 : {1'b0, dx};
    hy = mq == 2'd1 ? ({1'b0, dy} + 1'b1) >> 1 : {1'b0, dy};
    s = mq == 2'd2 ? (hx > hy ? hx : hy) : hx + hy;
    c = s == '0 ? '0 : s - 1'b1;
    sum = {1'b0, bus.cost} + (ACC_W+1)'(c);
    bad = &ax | &ay | &bx | &by;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      idx <= '0;
      nq <= '0;
      eb <= '0;
      mq <= '0;
      wc <= '0;
      ax <= '0;
      ay <= '0;
      bx <= '0;
      by <= '0;
      dx <= '0;
      dy <= '0;
      bus.edge_re <= 1'b0;
      bus.edge_addr <= '0;
      bus.pos_re <= 1'b0;
      bus.pos_addr <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.cost <= '0;
      bus.err <= 1'b0;
`ifdef PLACEMENT_COST_MAXTRACK_EN
      bus.max_cost <= '0;
      bus.max_idx <= '0;
`endif
    end else begin
      bus.edge_re <= 1'b0;
      bus.pos_re <= 1'b0;
      bus.done <= 1'b0;
      case (st)
        IDLE: if (bus.start) begin
          nq <= bus.n_edge;
          mq <= bus.mode;
          idx <= '0;
          bus.cost <= '0;
          bus.err <= bus.mode == 2'd3;
`ifdef PLACEMENT_COST_MAXTRACK_EN
          bus.max_cost <= '0;
          bus.max_idx <= '0;
`endif
          if (bus.mode == 2'd3 || bus.n_edge == '0) begin
            st <= DONE;
            bus.done <= 1'b1;
          end else begin
            st <= E_ISSUE;
            bus.busy <= 1'b1;
            bus.edge_re <= 1'b1;
            bus.edge_addr <= '0;
          end
        end
        E_ISSUE: begin
          st <= E_WAIT;
          wc <= '0;
        end
        E_WAIT: if (wc == WL) begin
          st <= A_ISSUE;
          eb <= bus.edge_b[ADDR_W-1:0];
          bus.pos_re <= 1'b1;
          bus.pos_addr <= bus.edge_a[ADDR_W-1:0];
        end else wc <= wc + 1'b1;
        A_ISSUE: begin
          st <= A_WAIT;
          wc <= '0;
        end
        A_WAIT: if (wc == WL) begin
          st <= B_ISSUE;
          ax <= bus.pos_x;
          ay <= bus.pos_y;
          bus.pos_re <= 1'b1;
          bus.pos_addr <= eb;
        end else wc <= wc + 1'b1;
        B_ISSUE: begin
          st <= B_WAIT;
          wc <= '0;
        end
        B_WAIT: if (wc == WL) begin
          st <= DIFF;
          bx <= bus.pos_x;
          by <= bus.pos_y;
        end else wc <= wc + 1'b1;
        DIFF: begin
          st <= ABS;
          dx <= {ax[DATA_W-1], ax} - {bx[DATA_W-1], bx};
          dy <= {ay[DATA_W-1], ay} - {by[DATA_W-1], by};
        end
        ABS: begin
          st <= ACC;
          dx <= dx[DATA_W] ? -dx : dx;
          dy <= dy[DATA_W] ? -dy : dy;
        end
        ACC: begin
          if (bad) bus.err <= 1'b1;
          else begin
            bus.cost <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`ifdef PLACEMENT_COST_MAXTRACK_EN
            if (c[DATA_W:0] > bus.max_cost) begin
              bus.max_cost <= c[DATA_W:0];
              bus.max_idx <= idx;
            end
`endif
          end
          idx <= idx + 1'b1;
          if (idx + 1'b1 == nq) begin
            st <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            st <= E_ISSUE;
            bus.edge_re <= 1'b1;
            bus.edge_addr <= idx + 1'b1;
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_placement_cost_eval.sv
// tb_placement_cost_eval: randomized self-checking bench for placement_cost_eval (MEM_LAT 1 and 3)
module tb_placement_cost_eval;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 40;
  localparam longint MAXACC = (longint'(1) << CW) - 1;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] st;
  logic [AW-1:0] n_edge;
  logic [1:0] mode;
  int sel;
  int nvec = 0;
  int nmis = 0;
  int ecnt = 0;
  int pcnt = 0;
  logic [31:0] ea_mem[256], eb_mem[256], px_mem[256], py_mem[256];
  logic [1:0] done_w, busy_w, err_w, ere_w, pre_w;
  logic [1:0][CW-1:0] cost_w;
  logic done_o, busy_o, err_o, ere_o, pre_o;
  logic [CW-1:0] cost_o;
`ifdef PLACEMENT_COST_MAXTRACK_EN
  logic [1:0][DW:0] mc_w;
  logic [1:0][AW-1:0] mi_w;
  logic [DW:0] mc_o;
  logic [AW-1:0] mi_o;
  assign mc_o = mc_w[sel[0]];
  assign mi_o = mi_w[sel[0]];
`endif
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g ? 3 : 1;
    placement_cost_eval_if #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(CW)) b();
    placement_cost_eval #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(CW), .MEM_LAT(L)) dut (.clk(clk), .reset(reset), .bus(b));
    logic [7:0] rq, pq;
    logic [7:0][AW-1:0] aq, qq;
    logic [8:0] rh, ph;
    logic [8:0][AW-1:0] ah, qh;
    assign rh = {rq, b.edge_re};
    assign ph = {pq, b.pos_re};
    assign ah = {aq, b.edge_addr};
    assign qh = {qq, b.pos_addr};
    assign b.start = st[g];
    assign b.n_edge = n_edge;
    assign b.mode = mode;
    always @(posedge clk) begin
      rq <= rh[7:0];
      pq <= ph[7:0];
      aq <= ah[7:0];
      qq <= qh[7:0];
      if (rh[L-1]) begin
        b.edge_a <= ea_mem[ah[L-1]];
        b.edge_b <= eb_mem[ah[L-1]];
      end
      if (ph[L-1]) begin
        b.pos_x <= px_mem[qh[L-1]];
        b.pos_y <= py_mem[qh[L-1]];
      end
    end
    assign done_w[g] = b.done;
    assign busy_w[g] = b.busy;
    assign err_w[g] = b.err;
    assign ere_w[g] = b.edge_re;
    assign pre_w[g] = b.pos_re;
    assign cost_w[g] = b.cost;
`ifdef PLACEMENT_COST_MAXTRACK_EN
    assign mc_w[g] = b.max_cost;
    assign mi_w[g] = b.max_idx;
`endif
  end
  assign done_o = done_w[sel[0]];
  assign busy_o = busy_w[sel[0]];
  assign err_o = err_w[sel[0]];
  assign ere_o = ere_w[sel[0]];
  assign pre_o = pre_w[sel[0]];
  assign cost_o = cost_w[sel[0]];
  always @(posedge clk) begin
    if (ere_o) ecnt <= ecnt + 1;
    if (pre_o) pcnt <= pcnt + 1;
  end
  task automatic model(input int n, input int md, output longint c, output logic e, output longint mc, output int mi);
    longint xa, ya, xb, yb, dx, dy, k;
    int a, bn;
    c = 0;
    e = md == 3;
    mc = 0;
    mi = 0;
    if (md == 3) return;
    for (int i = 0; i < n; i++) begin
      a = int'(ea_mem[i][7:0]);
      bn = int'(eb_mem[i][7:0]);
      if (px_mem[a] == 32'hFFFFFFFF || py_mem[a] == 32'hFFFFFFFF || px_mem[bn] == 32'hFFFFFFFF || py_mem[bn] == 32'hFFFFFFFF) begin
        e = 1'b1;
        continue;
      end
      xa = longint'($signed(px_mem[a]));
      ya = longint'($signed(py_mem[a]));
      xb = longint'($signed(px_mem[bn]));
      yb = longint'($signed(py_mem[bn]));
      dx = xa > xb ? xa - xb : xb - xa;
      dy = ya > yb ? ya - yb : yb - ya;
      k = md == 0 ? dx + dy - 1 : md == 1 ? (dx + 1) / 2 + (dy + 1) / 2 - 1 : (dx > dy ? dx : dy) - 1;
      if (k < 0) k = 0;
      c = c + k > MAXACC ? MAXACC : c + k;
      if (k > mc) begin
        mc = k;
        mi = i;
      end
    end
  endtask
  task automatic run(input int s, input int n, input int md, input bit poke, output int cyc);
    sel = s;
    @(negedge clk);
    n_edge = AW'(n);
    mode = 2'(md);
    st[s] = 1'b1;
    @(posedge clk);
    #1 st[s] = 1'b0;
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 4000) begin
      if (poke && cyc == 4) st[s] = 1'b1;
      @(posedge clk);
      #1 st[s] = 1'b0;
      cyc++;
    end
    if (poke) st[s] = 1'b1;
    @(posedge clk);
    #1 st[s] = 1'b0;
  endtask
  function automatic logic [31:0] rpos();
    int r = $urandom_range(0, 7);
    return r == 0 ? 32'hFFFFFFFF : r < 5 ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
  endfunction
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({busy_w, done_w, err_w, ere_w, pre_w} !== 10'd0) begin nmis++; $display("FAIL reset_flags: got %b want 0", {busy_w, done_w, err_w, ere_w, pre_w}); end
    nvec++;
    if (cost_w !== '0) begin nmis++; $display("FAIL reset_cost: got %h want 0", cost_w); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_basic();
    int want[3] = '{4, 2, 2};
    int cyc, e0, p0;
    ea_mem[0] = 0; eb_mem[0] = 1;
    px_mem[0] = 0; py_mem[0] = 0; px_mem[1] = 3; py_mem[1] = 2;
    for (int md = 0; md < 3; md++) begin
      e0 = ecnt; p0 = pcnt;
      run(0, 1, md, 0, cyc);
      nvec++;
      if (cost_o !== CW'(want[md])) begin nmis++; $display("FAIL basic_cost md=%0d: got %0d want %0d", md, cost_o, want[md]); end
      nvec++;
      if (cyc != 10) begin nmis++; $display("FAIL basic_cycle md=%0d: got %0d want 10", md, cyc); end
      nvec++;
      if ({err_o, done_o, busy_o} !== 3'b000) begin nmis++; $display("FAIL basic_flags md=%0d: got %b want 000", md, {err_o, done_o, busy_o}); end
      nvec++;
      if (ecnt - e0 != 1 || pcnt - p0 != 2) begin nmis++; $display("FAIL basic_strobes md=%0d: got %0d/%0d want 1/2", md, ecnt - e0, pcnt - p0); end
    end
  endtask
  task automatic test_coincident();
    int cyc;
    ea_mem[1] = 2; eb_mem[1] = 3;
    px_mem[2] = 1; py_mem[2] = 1; px_mem[3] = 1; py_mem[3] = 1;
    run(0, 2, 0, 0, cyc);
    nvec++;
    if (cost_o !== 40'd4 || err_o !== 1'b0) begin nmis++; $display("FAIL coincident: got cost %0d err %b want 4 0", cost_o, err_o); end
    nvec++;
    if (cyc != 19) begin nmis++; $display("FAIL coincident_cycle: got %0d want 19", cyc); end
  endtask
  task automatic test_unplaced();
    int cyc;
    ea_mem[1] = 4; eb_mem[1] = 5; ea_mem[2] = 0; eb_mem[2] = 1;
    px_mem[4] = 32'hFFFFFFFF; py_mem[4] = 32'hFFFFFFFF; px_mem[5] = 7; py_mem[5] = 7;
    run(0, 3, 0, 0, cyc);
    nvec++;
    if (cost_o !== 40'd8 || err_o !== 1'b1) begin nmis++; $display("FAIL unplaced: got cost %0d err %b want 8 1", cost_o, err_o); end
    nvec++;
    if (cyc != 28) begin nmis++; $display("FAIL unplaced_cycle: got %0d want 28", cyc); end
  endtask
  task automatic test_zero_illegal();
    int cyc, e0, p0;
    e0 = ecnt; p0 = pcnt;
    run(0, 0, 0, 0, cyc);
    nvec++;
    if (cyc != 1 || cost_o !== '0 || err_o !== 1'b0) begin nmis++; $display("FAIL zero_edges: got cyc %0d cost %0d err %b want 1 0 0", cyc, cost_o, err_o); end
    nvec++;
    if (ecnt != e0 || pcnt != p0) begin nmis++; $display("FAIL zero_strobes: got %0d/%0d want 0/0", ecnt - e0, pcnt - p0); end
    run(0, 3, 0, 0, cyc);
    run(0, 3, 3, 0, cyc);
    nvec++;
    if (cyc != 1 || cost_o !== '0 || err_o !== 1'b1) begin nmis++; $display("FAIL illegal_mode: got cyc %0d cost %0d err %b want 1 0 1", cyc, cost_o, err_o); end
  endtask
  task automatic test_lat3();
    int cyc, e0, p0;
    ea_mem[0] = 6; eb_mem[0] = 7;
    px_mem[6] = 0; py_mem[6] = 0; px_mem[7] = 4; py_mem[7] = 1;
    e0 = ecnt; p0 = pcnt;
    run(1, 1, 0, 1, cyc);
    nvec++;
    if (cost_o !== 40'd4 || cyc != 16) begin nmis++; $display("FAIL lat3: got cost %0d cyc %0d want 4 16", cost_o, cyc); end
    nvec++;
    if (ecnt - e0 != 1 || pcnt - p0 != 2) begin nmis++; $display("FAIL lat3_strobes: got %0d/%0d want 1/2", ecnt - e0, pcnt - p0); end
    @(posedge clk);
    #1;
    nvec++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin nmis++; $display("FAIL start_on_done: got busy %b done %b want 0 0", busy_o, done_o); end
  endtask
  task automatic test_reset_mid();
    int cyc;
    ea_mem[0] = 4; eb_mem[0] = 5; ea_mem[1] = 0; eb_mem[1] = 1; ea_mem[2] = 2; eb_mem[2] = 3;
    sel = 0;
    @(negedge clk);
    n_edge = 3; mode = 0; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    nvec++;
    if (cost_o !== 40'd4 || err_o !== 1'b1 || busy_o !== 1'b1) begin nmis++; $display("FAIL mid_run: got cost %0d err %b busy %b want 4 1 1", cost_o, err_o, busy_o); end
    reset = 1'b1;
    #1;
    nvec++;
    if (cost_o !== '0 || {err_o, done_o, busy_o} !== 3'b000) begin nmis++; $display("FAIL reset_mid: got cost %0d flags %b want 0 000", cost_o, {err_o, done_o, busy_o}); end
    @(negedge clk);
    reset = 1'b0;
    run(0, 3, 0, 0, cyc);
    nvec++;
    if (cost_o !== 40'd4 || err_o !== 1'b1 || cyc != 28) begin nmis++; $display("FAIL after_reset: got cost %0d err %b cyc %0d want 4 1 28", cost_o, err_o, cyc); end
  endtask
  task automatic test_saturation();
    int cyc;
    for (int i = 0; i < 200; i++) begin
      ea_mem[i] = {24'($urandom), 8'd10};
      eb_mem[i] = {24'($urandom), 8'd11};
    end
    px_mem[10] = 32'h80000000; py_mem[10] = 32'h80000000;
    px_mem[11] = 32'h7FFFFFFF; py_mem[11] = 32'h7FFFFFFF;
    run(0, 200, 0, 0, cyc);
    nvec++;
    if (cost_o !== 40'hFFFFFFFFFF || err_o !== 1'b0 || cyc != 1801) begin nmis++; $display("FAIL saturation: got cost %h err %b cyc %0d want ffffffffff 0 1801", cost_o, err_o, cyc); end
  endtask
  task automatic test_random();
    int s, n, md, cyc, e0, p0, wcyc, mi;
    longint c, mc;
    logic e;
    for (int t = 0; t < 24; t++) begin
      s = $urandom_range(0, 1);
      n = $urandom_range(1, 8);
      md = $urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        ea_mem[i] = $urandom;
        eb_mem[i] = $urandom;
        px_mem[ea_mem[i][7:0]] = rpos(); py_mem[ea_mem[i][7:0]] = rpos();
        px_mem[eb_mem[i][7:0]] = rpos(); py_mem[eb_mem[i][7:0]] = rpos();
      end
      model(n, md, c, e, mc, mi);
      wcyc = md == 3 ? 1 : 1 + n * (6 + 3 * (s ? 3 : 1));
      e0 = ecnt; p0 = pcnt;
      run(s, n, md, 0, cyc);
      nvec++;
      if (cost_o !== CW'(c) || err_o !== e) begin nmis++; $display("FAIL random t=%0d md=%0d: got cost %0d err %b want %0d %b", t, md, cost_o, err_o, c, e); end
      nvec++;
      if (cyc != wcyc) begin nmis++; $display("FAIL random_cycle t=%0d: got %0d want %0d", t, cyc, wcyc); end
      nvec++;
      if (ecnt - e0 != (md == 3 ? 0 : n) || pcnt - p0 != (md == 3 ? 0 : 2 * n)) begin nmis++; $display("FAIL random_strobes t=%0d: got %0d/%0d", t, ecnt - e0, pcnt - p0); end
`ifdef PLACEMENT_COST_MAXTRACK_EN
      nvec++;
      if (mc_o !== (DW+1)'(mc) || mi_o !== AW'(mi)) begin nmis++; $display("FAIL random_max t=%0d: got %0d@%0d want %0d@%0d", t, mc_o, mi_o, mc, mi); end
`endif
    end
  endtask
  initial begin
    reset = 1'b1;
    st = '0;
    n_edge = '0;
    mode = '0;
    sel = 0;
    test_reset();
    test_basic();
    test_coincident();
    test_unplaced();
    test_zero_illegal();
    test_lat3();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
